// File: rtl/demux_pkg.sv
// demux_pkg: shared types and constants for the demux_router slice.
package demux_pkg;

    // Occupancy of one output slot.
    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_st_t;

    // Width of the out-of-range beat counter.
    localparam int ERR_CNT_W = 8;

    // Increment that sticks at the all-ones value instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] value);
        return (value == {ERR_CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// demux_slot: one-entry registered output slot. Loads on 'load', drains when the
// consumer takes the beat, and can drain and reload in the same cycle.
module demux_slot
    import demux_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             out_ready,
    output logic             full,
    output logic [WIDTH-1:0] data
);

    slot_st_t         state_reg, state_next;
    logic [WIDTH-1:0] data_reg, data_next;

    // State and payload registers; reset discards any held beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SLOT_EMPTY;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
        end
    end

    // Next state: a load always wins (fill or drain+refill), otherwise drain on ready.
    // The parent only asserts load when the slot is empty or draining this cycle.
    always_comb begin
        state_next = state_reg;
        data_next  = data_reg;
        case (state_reg)
            SLOT_EMPTY: begin
                if (load) begin
                    state_next = SLOT_FULL;
                    data_next  = load_data;
                end
            end
            SLOT_FULL: begin
                if (load) begin
                    data_next = load_data;
                end else if (out_ready) begin
                    state_next = SLOT_EMPTY;
                end
            end
            default: state_next = SLOT_EMPTY;
        endcase
    end

    assign full = (state_reg == SLOT_FULL);
    assign data = data_reg;

endmodule

// File: rtl/demux_router.sv
// demux_router: 1-to-N valid/ready demultiplexer with one registered slot per output.
// Optional feature macro: DEMUX_ERR_EN adds the err pulse and err_cnt counter for
// out-of-range selects; without it such beats are accepted and silently dropped.
module demux_router
    import demux_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int N_OUT = 4,
    parameter int SEL_W = $clog2(N_OUT)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SEL_W-1:0]       in_sel,
    output logic [N_OUT-1:0]       out_valid,
    input  logic [N_OUT-1:0]       out_ready,
    output logic [N_OUT*WIDTH-1:0] out_data
`ifdef DEMUX_ERR_EN
    ,
    output logic                   err,
    output logic [ERR_CNT_W-1:0]   err_cnt
`endif
);

    logic [N_OUT-1:0] slot_full;
    logic [N_OUT-1:0] slot_load;
    logic [N_OUT-1:0] slot_block;
    logic             xfer;

    // A transfer never captures while reset is held, even if in_ready is high.
    assign xfer     = in_valid && in_ready && !rst;
    // Only a full, non-draining target slot can stall the input; an out-of-range
    // select matches no slot and is therefore always accepted.
    assign in_ready = ~|slot_block;

    for (genvar gi = 0; gi < N_OUT; gi++) begin : g_slot
        assign slot_block[gi] = (in_sel == SEL_W'(gi)) && slot_full[gi] && !out_ready[gi];
        assign slot_load[gi]  = xfer && (in_sel == SEL_W'(gi));

        demux_slot #(
            .WIDTH (WIDTH)
        ) u_slot (
            .clk       (clk),
            .rst       (rst),
            .load      (slot_load[gi]),
            .load_data (in_data),
            .out_ready (out_ready[gi]),
            .full      (slot_full[gi]),
            .data      (out_data[gi*WIDTH +: WIDTH])
        );
    end

    assign out_valid = slot_full;

`ifdef DEMUX_ERR_EN
    localparam logic [SEL_W:0] N_OUT_L = (SEL_W+1)'(N_OUT);

    logic                 sel_in_range;
    logic                 err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    assign sel_in_range = ({1'b0, in_sel} < N_OUT_L);

    // One-cycle error pulse and saturating count for each dropped out-of-range beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_reg     <= 1'b0;
            err_cnt_reg <= '0;
        end else begin
            err_reg <= xfer && !sel_in_range;
            if (xfer && !sel_in_range) begin
                err_cnt_reg <= sat_inc(err_cnt_reg);
            end
        end
    end

    assign err     = err_reg;
    assign err_cnt = err_cnt_reg;
`endif

endmodule

// File: tb/tb_demux_router.sv
// tb_demux_router: drives a 4-output and a 3-output demux_router with the same
// stimulus and checks both against a slot-occupancy model kept in the bench.
module tb_demux_router;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_ready;

    logic        rdy4, rdy3;
    logic [3:0]  ov4;
    logic [2:0]  ov3;
    logic [31:0] od4;
    logic [23:0] od3;
`ifdef DEMUX_ERR_EN
    logic        err4, err3;
    logic [7:0]  cnt4, cnt3;
`endif

    always #5 clk = ~clk;

    demux_router #(.WIDTH(8), .N_OUT(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy4), .in_data(in_data),
        .in_sel(in_sel), .out_valid(ov4), .out_ready(out_ready), .out_data(od4)
`ifdef DEMUX_ERR_EN
        , .err(err4), .err_cnt(cnt4)
`endif
    );

    demux_router #(.WIDTH(8), .N_OUT(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy3), .in_data(in_data),
        .in_sel(in_sel), .out_valid(ov3), .out_ready(out_ready[2:0]), .out_data(od3)
`ifdef DEMUX_ERR_EN
        , .err(err3), .err_cnt(cnt3)
`endif
    );

    // Reference model: index 0 models the 4-output DUT, index 1 the 3-output DUT.
    int         n_out [2] = '{4, 3};
    bit         m_full[2][4];
    logic [7:0] m_data[2][4];
    bit         m_err [2];
    logic [7:0] m_cnt [2];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Beat is accepted if it targets nothing, an empty slot, or a slot being drained.
    function automatic bit exp_ready(input int k, input int sel, input logic [3:0] ordy);
        if (sel >= n_out[k]) return 1'b1;
        return !m_full[k][sel] || ordy[sel];
    endfunction

    task automatic check_outputs(input string tag);
        logic [3:0]  ov, ev;
        logic [31:0] od, ed, mask;
        for (int k = 0; k < 2; k++) begin
            ov   = (k == 0) ? ov4 : {1'b0, ov3};
            od   = (k == 0) ? od4 : {8'h00, od3};
            ev   = '0;
            ed   = '0;
            mask = '0;
            for (int i = 0; i < n_out[k]; i++) begin
                ev[i] = m_full[k][i];
                if (m_full[k][i]) begin
                    ed[i*8 +: 8]   = m_data[k][i];
                    mask[i*8 +: 8] = 8'hFF;
                end
            end
            check($sformatf("%s n%0d out_valid", tag, n_out[k]), 32'(ov), 32'(ev));
            check($sformatf("%s n%0d out_data", tag, n_out[k]), od & mask, ed);
`ifdef DEMUX_ERR_EN
            check($sformatf("%s n%0d err", tag, n_out[k]), 32'((k == 0) ? err4 : err3), 32'(m_err[k]));
            check($sformatf("%s n%0d err_cnt", tag, n_out[k]), 32'((k == 0) ? cnt4 : cnt3), 32'(m_cnt[k]));
`endif
        end
    endtask

    // One clock cycle: drive inputs, check in_ready mid-cycle, advance model, check outputs.
    task automatic step(input string tag, input bit v, input logic [7:0] d,
                        input logic [1:0] s, input logic [3:0] ordy);
        bit acc[2];
        in_valid  = v;
        in_data   = d;
        in_sel    = s;
        out_ready = ordy;
        #4;
        for (int k = 0; k < 2; k++) begin
            acc[k] = v && exp_ready(k, int'(s), ordy) && !rst;
            if (!rst)
                check($sformatf("%s n%0d in_ready", tag, n_out[k]),
                      32'((k == 0) ? rdy4 : rdy3), 32'(exp_ready(k, int'(s), ordy)));
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int i = 0; i < 4; i++) begin
                    m_full[k][i] = 1'b0;
                    m_data[k][i] = 8'h00;
                end
                m_err[k] = 1'b0;
                m_cnt[k] = 8'h00;
            end else begin
                for (int i = 0; i < n_out[k]; i++)
                    if (m_full[k][i] && ordy[i]) m_full[k][i] = 1'b0;
                m_err[k] = acc[k] && (int'(s) >= n_out[k]);
                if (acc[k] && int'(s) < n_out[k]) begin
                    m_full[k][s] = 1'b1;
                    m_data[k][s] = d;
                end
                if (m_err[k] && m_cnt[k] != 8'hFF) m_cnt[k] = m_cnt[k] + 8'h01;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_data   = 8'h5A;
        in_sel    = 2'd1;
        out_ready = 4'hF;
        @(posedge clk);
        #1;

        // Reset held two cycles with a valid beat pending.
        step("reset0", 1'b1, 8'h5A, 2'd1, 4'hF);
        step("reset1", 1'b1, 8'h5A, 2'd1, 4'hF);
        check("reset n4 out_data zero", od4, 32'h0);
        check("reset n3 out_data zero", 32'(od3), 32'h0);
        rst = 1'b0;
        step("post_reset_idle", 1'b0, 8'h00, 2'd0, 4'hF);

        // Basic routing with every consumer ready.
        step("route_a1", 1'b1, 8'hA1, 2'd0, 4'hF);
        check("route_a1 n4 lands on out0", od4[7:0], 32'hA1);
        step("route_b2", 1'b1, 8'hB2, 2'd2, 4'hF);
        step("route_c3", 1'b1, 8'hC3, 2'd3, 4'hF);
        check("route_c3 n4 valid only out3", 32'(ov4), 32'h8);
        step("route_idle", 1'b0, 8'h00, 2'd0, 4'hF);

        // Back-pressure on output 1.
        step("bp_11", 1'b1, 8'h11, 2'd1, 4'b1101);
        step("bp_22_stall", 1'b1, 8'h22, 2'd1, 4'b1101);
        check("bp_22_stall n4 held 11", od4[15:8], 32'h11);
        step("bp_22_drain_refill", 1'b1, 8'h22, 2'd1, 4'hF);
        check("bp_22 n4 arrives", od4[15:8], 32'h22);
        step("bp_idle", 1'b0, 8'h00, 2'd0, 4'hF);

        // Independent drain: slot 1 stalled full, slot 0 still flows.
        step("ind_fill1", 1'b1, 8'h30, 2'd1, 4'b1101);
        step("ind_33", 1'b1, 8'h33, 2'd0, 4'b1101);
        check("ind_33 n4 slot1 unchanged", od4[15:8], 32'h30);
        step("ind_idle", 1'b0, 8'h00, 2'd0, 4'b1101);
        step("ind_release", 1'b0, 8'h00, 2'd0, 4'hF);

        // Out-of-range select on the 3-output DUT, then saturate the counter.
        step("oor_44", 1'b1, 8'h44, 2'd3, 4'hF);
        check("oor_44 n3 no valid", 32'(ov3), 32'h0);
        step("oor_idle", 1'b0, 8'h00, 2'd0, 4'hF);
        for (int i = 0; i < 300; i++)
            step("oor_sat", 1'b1, 8'(i), 2'd3, 4'hF);
`ifdef DEMUX_ERR_EN
        check("oor_sat n3 err_cnt", 32'(cnt3), 32'd255);
`endif

        // Reset mid-operation discards held beats.
        step("mid_fill0", 1'b1, 8'h91, 2'd0, 4'h0);
        step("mid_fill2", 1'b1, 8'h92, 2'd2, 4'h0);
        rst = 1'b1;
        step("mid_reset", 1'b1, 8'h93, 2'd1, 4'h0);
        rst = 1'b0;
        step("mid_after", 1'b0, 8'h00, 2'd0, 4'h0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++)
            step("rand", 1'($urandom), 8'($urandom), 2'($urandom), 4'($urandom));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/demux_router.md
# demux_router

Sequential 1-to-N demultiplexer with a valid/ready handshake: one input stream is steered to one of `N_OUT` output streams by a per-beat select. Each output owns a one-entry registered slot, so back-pressure on one output never corrupts another. The block sits downstream of the add/subtract mux datapath and fans its results out to independent consumers.

## Interface
Parameters:
- `WIDTH`, default 8: data width per beat.
- `N_OUT`, default 4: number of outputs; must be at least 2.
- `SEL_W`, default `$clog2(N_OUT)`: select width; derived, not to be overridden.

Ports (one clock; reset is synchronous and active-high):
- `clk`, input, 1 bit: single clock; all state updates on the rising edge.
- `rst`, input, 1 bit: synchronous, active-high reset.
- `in_valid`, input, 1 bit: input beat present.
- `in_ready`, output, 1 bit: block can accept the beat this cycle.
- `in_data`, input, `WIDTH` bits: input payload.
- `in_sel`, input, `SEL_W` bits: destination output index.
- `out_valid`, output, `N_OUT` bits: per-output valid.
- `out_ready`, input, `N_OUT` bits: per-output ready.
- `out_data`, output, `N_OUT*WIDTH` bits: flattened payloads; output *i* is bits `[i*WIDTH +: WIDTH]`.
- `err`, output, 1 bit: one-cycle pulse when an out-of-range select is accepted. Present only with `DEMUX_ERR_EN`.
- `err_cnt`, output, 8 bits: saturating count of out-of-range beats. Present only with `DEMUX_ERR_EN`.

## Operation
- Each output slot is a two-state FSM.
  - EMPTY → FULL on an accepted beat addressed to that slot.
  - FULL → EMPTY when `out_valid[i]` and `out_ready[i]` are both high and no new beat arrives for that slot.
  - FULL → FULL when the slot drains and is refilled in the same cycle; data is replaced by the new beat.
- Acceptance:
  - `in_ready` is combinational: high when `in_sel` is in range and slot[`in_sel`] is EMPTY, or when slot[`in_sel`] is FULL and `out_ready[in_sel]` is high.
  - `in_ready` is also high when `in_sel >= N_OUT`; that beat is accepted and dropped.
  - A transfer occurs when `in_valid` and `in_ready` are both high.
- `out_valid[i]` is high exactly when slot *i* is FULL. `out_data` slice *i* holds the captured beat and is stable while FULL and unacknowledged.
- Only the selected slot can load. All other slots drain independently in the same cycle.
- `in_data` is not modified; width is preserved and there is no arithmetic.
- Reset values: all slots EMPTY, `out_valid` = 0, `out_data` = 0, `err` = 0, `err_cnt` = 0.
- Reset mid-operation: any held beats are discarded. `in_ready` may be high during reset, but nothing is captured while `rst` is high.

## Timing
- Latency: a beat accepted at edge *k* shows `out_valid[sel]` = 1 after edge *k*, i.e. one cycle.
- Throughput: one beat per cycle into any output whose `out_ready` is held high. Back-to-back beats to the same output sustain full rate.
- Stall: with `out_ready[i]` low and slot *i* FULL, `in_ready` is low for `in_sel` = *i* and high for every other EMPTY target.
- Simultaneous drain and refill of one slot: there are no bubbles and no data loss.
- `err` pulses in the cycle after an out-of-range beat is accepted. `err_cnt` updates on the same edge and saturates at 255.

## Configuration
- Macro: `DEMUX_ERR_EN`.
- Defined: the `err` and `err_cnt` ports exist with the behaviour above.
- Undefined: the ports and their logic are absent. Out-of-range beats are still accepted and silently dropped. Every other behaviour is identical.

## Structure
- Package `demux_pkg`:
  - slot state enum `slot_st_t` with values `SLOT_EMPTY` and `SLOT_FULL`.
  - constant `ERR_CNT_W` = 8.
- Sub-module `demux_slot`, instantiated `N_OUT` times in a generate loop.
  - Inputs: `load`, `load_data`, `out_ready`.
  - Outputs: `full`, `data`.
- Top level: the `in_ready` decode and the error logic.

## Test plan
- Reset: assert `rst` for 2 cycles with `in_valid` = 1 → all `out_valid` = 0, `out_data` = 0, and after release no stale beat appears.
- Basic routing, `N_OUT` = 4, all `out_ready` = 1: send 0xA1 to sel 0, 0xB2 to sel 2, 0xC3 to sel 3 on consecutive cycles → each appears one cycle later on the matching output only.
- Back-pressure: `out_ready[1]` = 0, send 0x11 then 0x22 to sel 1 → 0x11 held and `in_ready` = 0 for the second beat. Raise `out_ready[1]` → 0x22 is accepted in the same cycle 0x11 drains, and arrives next cycle.
- Independent drain: slot 1 stalled FULL; send 0x33 to sel 0 → accepted immediately and delivered on output 0, slot 1 unchanged.
- Out-of-range (`DEMUX_ERR_EN`, `N_OUT` = 3): send `in_sel` = 3 with 0x44 → `in_ready` = 1, no `out_valid` change, `err` pulses once, `err_cnt` = 1. Send 300 such beats → `err_cnt` saturates at 255.
- Macro off, `N_OUT` = 3, `in_sel` = 3 → beat dropped and all outputs unchanged.
